// File: rtl/cycle_wait_arbiter.sv
// cycle_wait_arbiter
//   Round-robin arbiter that owns one shared down-counter and times a single
//   wait at a time on behalf of one of NREQ requesters.
//
// Ports
//   clk      in   1          rising-edge clock
//   rst_n    in   1          synchronous active-low reset
//   req      in   NREQ       per-requester wait request (level, held until ack)
//   cycles   in   NREQ*CW    per-requester wait length, slice i = [i*CW +: CW]
//   abort    in   1          cancels the wait in progress (honoured in RUN only)
//   ack      out  NREQ       one-hot pulse, the requester just granted
//   done     out  NREQ       one-hot pulse, the wait of owner completed
//   aborted  out  1          pulse, the wait of owner was cancelled
//   busy     out  1          high from the ack cycle through done/aborted
//   owner    out  clog2 NREQ current or most recent grantee
module cycle_wait_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*CW-1:0]        cycles,
  input  logic                      abort,
  output logic [NREQ-1:0]           ack,
  output logic [NREQ-1:0]           done,
  output logic                      aborted,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   owner
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [OW-1:0]   last, last_d;
  logic [OW-1:0]   owner_d;
  logic [NREQ-1:0] ack_d, done_d;
  logic            aborted_d, busy_d;

  logic            found;
  logic [OW-1:0]   win;
  logic [CW-1:0]   win_n;

  // Round-robin search starting one past the most recent grantee.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
    win_n = cycles[int'(win)*CW +: CW];
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    last_d    = last;
    owner_d   = owner;
    ack_d     = '0;
    done_d    = '0;
    aborted_d = 1'b0;
    busy_d    = 1'b0;
    case (state)
      IDLE: begin
        // A registered done means the previous service just finished; hold
        // off one cycle so every completed service is followed by an idle
        // cycle. An aborted wait does not impose this gap.
        if (found && (done == '0)) begin
          ack_d[win] = 1'b1;
          owner_d    = win;
          last_d     = win;
          cnt_d      = win_n;
          busy_d     = 1'b1;
          state_d    = (win_n <= CW'(1)) ? FIN : RUN;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          // Counter still holds N on the first RUN edge, so reaching 2 here
          // lines done up exactly N cycles after ack.
          cnt_d = cnt - CW'(1);
          if (cnt == CW'(2)) state_d = FIN;
        end
      end
      FIN: begin
        busy_d        = 1'b1;
        done_d[owner] = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      // Pointing at the last requester gives requester 0 first priority.
      last    <= OW'(NREQ - 1);
      owner   <= '0;
      ack     <= '0;
      done    <= '0;
      aborted <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      last    <= last_d;
      owner   <= owner_d;
      ack     <= ack_d;
      done    <= done_d;
      aborted <= aborted_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_cycle_wait_arbiter.sv
// Directed testbench for cycle_wait_arbiter (NREQ=4, CW=4).
module tb_cycle_wait_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*CW-1:0]    cycles;
  logic                  abort;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       done;
  logic                  aborted;
  logic                  busy;
  logic [1:0]            owner;

  int vectors;
  int errors;

  cycle_wait_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .cycles  (cycles),
    .abort   (abort),
    .ack     (ack),
    .done    (done),
    .aborted (aborted),
    .busy    (busy),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs then show the cycle after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    abort  = 1'b0;
    cycles = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    abort = 1'b0;
    step();
    step();
    vectors++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
    vectors++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
    vectors++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %b want 0", aborted); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", owner); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] exp_done;
    logic       exp_busy;
    do_reset();
    cycles[0*CW +: CW] = 4'd3;
    req = 4'b0001;
    step();
    vectors++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b want 0001", ack); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_ack: got %b want 1", busy); end
    vectors++; if (owner !== 2'd0) begin errors++; $display("FAIL single_owner: got %0d want 0", owner); end
    req = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_done = (k == 3) ? 4'b0001 : 4'b0000;
      exp_busy = (k <= 3);
      vectors++; if (done !== exp_done) begin errors++; $display("FAIL single_done k=%0d: got %b want %b", k, done, exp_done); end
      vectors++; if (busy !== exp_busy) begin errors++; $display("FAIL single_busy k=%0d: got %b want %b", k, busy, exp_busy); end
      vectors++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse k=%0d: got %b want 0000", k, ack); end
    end
  endtask

  task automatic test_zero_one();
    for (int n = 0; n <= 1; n++) begin
      do_reset();
      cycles[2*CW +: CW] = CW'(n);
      req = 4'b0100;
      step();
      vectors++; if (ack !== 4'b0100) begin errors++; $display("FAIL zo_ack n=%0d: got %b want 0100", n, ack); end
      vectors++; if (done !== 4'b0000) begin errors++; $display("FAIL zo_done_early n=%0d: got %b want 0000", n, done); end
      req = 4'b0000;
      step();
      vectors++; if (done !== 4'b0100) begin errors++; $display("FAIL zo_done n=%0d: got %b want 0100", n, done); end
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL zo_busy n=%0d: got %b want 1", n, busy); end
      step();
      vectors++; if (done !== 4'b0000) begin errors++; $display("FAIL zo_done_pulse n=%0d: got %b want 0000", n, done); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL zo_busy_end n=%0d: got %b want 0", n, busy); end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] one;
    logic [3:0] exp_ack;
    logic [3:0] exp_done;
    logic       exp_busy;
    one = 4'b0001;
    do_reset();
    for (int i = 0; i < NREQ; i++) cycles[i*CW +: CW] = 4'd2;
    req = 4'b1111;
    for (int t = 1; t <= 17; t++) begin
      step();
      exp_ack  = (t % 4 == 1) ? (one << (((t - 1) / 4) % 4)) : 4'b0000;
      exp_done = (t % 4 == 3) ? (one << (((t - 3) / 4) % 4)) : 4'b0000;
      exp_busy = (t % 4 != 0);
      vectors++; if (ack !== exp_ack) begin errors++; $display("FAIL rr_ack t=%0d: got %b want %b", t, ack, exp_ack); end
      vectors++; if (done !== exp_done) begin errors++; $display("FAIL rr_done t=%0d: got %b want %b", t, done, exp_done); end
      vectors++; if (busy !== exp_busy) begin errors++; $display("FAIL rr_busy t=%0d: got %b want %b", t, busy, exp_busy); end
      if (t % 4 == 1) begin
        vectors++; if (owner !== 2'(((t - 1) / 4) % 4)) begin errors++; $display("FAIL rr_owner t=%0d: got %0d want %0d", t, owner, ((t - 1) / 4) % 4); end
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_abort();
    do_reset();
    cycles[2*CW +: CW] = 4'd10;
    cycles[1*CW +: CW] = 4'd0;
    req = 4'b0100;
    step();
    vectors++; if (ack !== 4'b0100) begin errors++; $display("FAIL ab_ack: got %b want 0100", ack); end
    vectors++; if (owner !== 2'd2) begin errors++; $display("FAIL ab_owner: got %0d want 2", owner); end
    req = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++; if (busy !== 1'b1 || done !== 4'b0000) begin errors++; $display("FAIL ab_run k=%0d: got busy=%b done=%b want busy=1 done=0000", k, busy, done); end
    end
    abort = 1'b1;
    req   = 4'b0010;
    step();
    abort = 1'b0;
    vectors++; if (aborted !== 1'b1) begin errors++; $display("FAIL ab_pulse: got %b want 1", aborted); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL ab_busy: got %b want 1", busy); end
    vectors++; if (done !== 4'b0000) begin errors++; $display("FAIL ab_no_done: got %b want 0000", done); end
    step();
    vectors++; if (aborted !== 1'b0) begin errors++; $display("FAIL ab_pulse_end: got %b want 0", aborted); end
    vectors++; if (ack !== 4'b0010) begin errors++; $display("FAIL ab_next_ack: got %b want 0010", ack); end
    vectors++; if (owner !== 2'd1) begin errors++; $display("FAIL ab_next_owner: got %0d want 1", owner); end
    req = 4'b0000;
    step();
    vectors++; if (done !== 4'b0010) begin errors++; $display("FAIL ab_next_done: got %b want 0010", done); end
    for (int k = 0; k < 6; k++) begin
      step();
      vectors++; if (done !== 4'b0000) begin errors++; $display("FAIL ab_late_done k=%0d: got %b want 0000", k, done); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycles[0*CW +: CW] = 4'd8;
    cycles[1*CW +: CW] = 4'd0;
    req = 4'b0001;
    step();
    vectors++; if (ack !== 4'b0001) begin errors++; $display("FAIL rm_ack: got %b want 0001", ack); end
    req = 4'b0000;
    for (int k = 1; k <= 3; k++) step();
    rst_n = 1'b0;
    req   = 4'b0010;
    step();
    vectors++; if ({ack, done, aborted, busy, owner} !== 13'd0) begin errors++; $display("FAIL rm_outputs: got ack=%b done=%b ab=%b busy=%b own=%0d want all 0", ack, done, aborted, busy, owner); end
    step();
    vectors++; if ({ack, done, aborted, busy} !== 10'd0) begin errors++; $display("FAIL rm_outputs2: got ack=%b done=%b ab=%b busy=%b want all 0", ack, done, aborted, busy); end
    rst_n = 1'b1;
    step();
    vectors++; if (ack !== 4'b0010) begin errors++; $display("FAIL rm_release_ack: got %b want 0010", ack); end
    vectors++; if (owner !== 2'd1) begin errors++; $display("FAIL rm_release_owner: got %0d want 1", owner); end
    req = 4'b0000;
    step();
    vectors++; if (done !== 4'b0010) begin errors++; $display("FAIL rm_release_done: got %b want 0010", done); end
    for (int k = 0; k < 6; k++) begin
      step();
      vectors++; if (done !== 4'b0000 || aborted !== 1'b0) begin errors++; $display("FAIL rm_silent k=%0d: got done=%b ab=%b want 0000/0", k, done, aborted); end
    end
  endtask

  task automatic test_max();
    logic [3:0] exp_done;
    logic       exp_busy;
    do_reset();
    cycles[3*CW +: CW] = 4'd15;
    req = 4'b1000;
    step();
    vectors++; if (ack !== 4'b1000) begin errors++; $display("FAIL max_ack: got %b want 1000", ack); end
    vectors++; if (owner !== 2'd3) begin errors++; $display("FAIL max_owner: got %0d want 3", owner); end
    req = 4'b0000;
    for (int k = 1; k <= 17; k++) begin
      step();
      // A late change to cycles must not disturb the wait already running.
      if (k == 2) cycles[3*CW +: CW] = 4'd2;
      exp_done = (k == 15) ? 4'b1000 : 4'b0000;
      exp_busy = (k <= 15);
      vectors++; if (done !== exp_done) begin errors++; $display("FAIL max_done k=%0d: got %b want %b", k, done, exp_done); end
      vectors++; if (busy !== exp_busy) begin errors++; $display("FAIL max_busy k=%0d: got %b want %b", k, busy, exp_busy); end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    req     = '0;
    cycles  = '0;
    abort   = 1'b0;
    test_reset();
    test_single();
    test_zero_one();
    test_fairness();
    test_abort();
    test_reset_mid();
    test_max();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cycle_wait_arbiter.md
CYCLE_WAIT_ARBITER -- requirements
Module: cycle_wait_arbiter

Interface
- Parameters:
  - REQ-001: NREQ, default 4, is the number of requesters (2..8).
  - REQ-002: CW, default 16, is the width of the wait-count field.
- Ports (name, direction, width, meaning):
  - REQ-003: clk, input, 1, the single clock; all logic updates on the rising edge.
  - REQ-004: rst_n, input, 1, synchronous active-low reset sampled on the clk rising edge.
  - REQ-005: req, input, NREQ, per-requester wait request, level; held until ack.
  - REQ-006: cycles, input, NREQ*CW, per-requester wait length N; slice i is bits [i*CW +: CW].
  - REQ-007: abort, input, 1, cancels the wait in progress.
  - REQ-008: ack, output, NREQ, one-hot single-cycle pulse marking the accepted requester.
  - REQ-009: done, output, NREQ, one-hot single-cycle pulse marking wait completion.
  - REQ-010: aborted, output, 1, single-cycle pulse marking a cancelled wait.
  - REQ-011: busy, output, 1, high from ack through the done or aborted cycle inclusive.
  - REQ-012: owner, output, clog2(NREQ), index of the current or most recent grantee.

Function
- Core behaviour:
  - REQ-013: The block shall own one shared down-counter and serve exactly one wait at a time.
  - REQ-014: The FSM states shall be IDLE, RUN and FIN; reset state is IDLE.
- IDLE:
  - REQ-015: At a rising edge E with any req bit high, the block shall grant one requester round-robin.
  - REQ-016: The search shall start at index (last_owner+1) mod NREQ.
  - REQ-017: At E the block shall load counter = N of the winner, set owner, and assert ack[owner] and busy during cycle E..E+1.
  - REQ-018: ack shall stay high for exactly one cycle.
- Leaving IDLE:
  - REQ-019: If N <= 1, the next state shall be FIN.
  - REQ-020: Otherwise the next state shall be RUN.
- RUN:
  - REQ-021: The counter shall decrement by 1 per cycle.
  - REQ-022: When counter == 2 at an edge, the next state shall be FIN.
  - REQ-023: The net effect is that done[owner] is high during cycle E+max(N,1)..E+max(N,1)+1.
- FIN:
  - REQ-024: done[owner] shall be high for one cycle.
  - REQ-025: The next state shall be IDLE.
  - REQ-026: The next grant shall occur at the earliest one edge after the FIN cycle, so there is one idle cycle between services.
- Requester rules:
  - REQ-027: A req bit dropped before ack is a withdrawn request; the block shall not service it.
  - REQ-028: A req bit still high after done is a new request.
  - REQ-029: Requesters shall deassert req in the ack cycle.
- Input sampling:
  - REQ-030: cycles shall be sampled only at the grant edge.
  - REQ-031: Later changes to cycles shall not affect the wait in progress.
- Abort:
  - REQ-032: abort high at an edge in RUN shall move the FSM to IDLE.
  - REQ-033: That abort shall pulse aborted for one cycle and suppress done.
  - REQ-034: That abort shall keep busy high during the aborted cycle.
  - REQ-035: abort shall be ignored in IDLE and FIN; a FIN in progress still delivers done.
- Round-robin pointer:
  - REQ-036: The pointer shall update only on a grant.
  - REQ-037: Aborted and completed waits shall both count as served.
- Output guarantees:
  - REQ-038: ack, done and aborted shall each be one-hot or zero.
  - REQ-039: At most one of (any ack, any done, aborted) shall be high in a cycle.
  - REQ-040: All outputs shall be registered.
- Width:
  - REQ-041: The counter is CW bits.
  - REQ-042: N = 2^CW-1 shall be legal and shall wait exactly 2^CW-1 cycles with no wrap.

Reset
- REQ-043: With rst_n low at an edge, the FSM shall enter IDLE and the counter shall clear.
- REQ-044: Under reset, ack, done and aborted shall be 0, busy shall be 0 and owner shall be 0.
- REQ-045: Under reset, the round-robin pointer shall be set so that requester 0 has first priority.
- REQ-046: A reset during RUN or FIN shall drop the wait silently, with no done and no aborted.
- REQ-047: Requests high at reset release shall be granted at the first edge with rst_n high.

Verification
- REQ-048: Single wait: req[0]=1 with N=3 granted at edge E -> ack[0] in cycle E; done[0] in cycle E+3; busy high over 4 cycles; owner=0.
- REQ-049: Zero and one: N=0 -> done one cycle after ack; N=1 -> done one cycle after ack; both give identical timing.
- REQ-050: Fairness: req=4'b1111 held continuously with N=2 each -> grants in order 0,1,2,3,0; each grant is 4 cycles apart (ack, run, done, idle).
- REQ-051: Abort: req[2] with N=10, abort pulsed 4 cycles after ack -> aborted pulse next cycle; no done[2]; the next request is granted at the edge after aborted.
- REQ-052: Reset mid-wait: N=8, rst_n low 3 cycles after ack -> all outputs 0; no done; req[1] high at release -> ack[1] at the first edge.
- REQ-053: Max count with CW=4: N=15 -> done exactly 15 cycles after ack; the counter never wraps.
